// File: rtl/debug_pattern_gen.sv
// Colour-bar row generator standing in for the camera front end. It fills ping-pong dual-clock
// row buffers in clk_cam and announces each finished row to the clk_mem side.

module Reset_Synchronizer #(
  parameter int unsigned EXTRA_DEPTH = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic rst_o
);
  localparam int unsigned Depth = 2 + EXTRA_DEPTH;

  logic [Depth-1:0] sync_q;

  // Asynchronous assert, release shifted in over Depth edges.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[Depth-2:0], 1'b0};
    end
  end

  assign rst_o = sync_q[Depth-1];
endmodule

module CDC_Word_Synchronizer #(
  parameter int unsigned WORD_WIDTH      = 2,
  parameter int unsigned EXTRA_CDC_DEPTH = 1
) (
  input  logic                  snd_clk_i,
  input  logic                  snd_rst_i,
  input  logic [WORD_WIDTH-1:0] snd_data_i,
  input  logic                  snd_valid_i,
  output logic                  snd_ready_o,
  input  logic                  rcv_clk_i,
  input  logic                  rcv_rst_i,
  output logic [WORD_WIDTH-1:0] rcv_data_o,
  output logic                  rcv_valid_o,
  input  logic                  rcv_ready_i
);
  localparam int unsigned Depth = 2 + EXTRA_CDC_DEPTH;

  logic                  busy_q;
  logic                  req_q;
  logic [WORD_WIDTH-1:0] word_q;
  logic [Depth-1:0]      ack_sync_q;
  logic                  ack_q;
  logic [Depth-1:0]      req_sync_q;
  logic                  req_seen_q;
  logic [WORD_WIDTH-1:0] out_q;
  logic                  out_valid_q;
  logic                  done;
  logic                  load;

  // The sender only sees ready once the receiver has consumed the word, so the
  // producer stays stalled for as long as the consumer withholds acceptance.
  assign done        = busy_q && (ack_sync_q[Depth-1] == req_q);
  assign snd_ready_o = done;

  always_ff @(posedge snd_clk_i or posedge snd_rst_i) begin
    if (snd_rst_i) begin
      busy_q     <= 1'b0;
      req_q      <= 1'b0;
      word_q     <= '0;
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[Depth-2:0], ack_q};
      if (done) begin
        busy_q <= 1'b0;
      end else if (snd_valid_i && !busy_q) begin
        busy_q <= 1'b1;
        req_q  <= ~req_q;
        word_q <= snd_data_i;
      end
    end
  end

  // word_q is held static from launch until ack returns, so it is sampled directly.
  assign load = (req_sync_q[Depth-1] != req_seen_q) && !out_valid_q;

  always_ff @(posedge rcv_clk_i or posedge rcv_rst_i) begin
    if (rcv_rst_i) begin
      req_sync_q  <= '0;
      req_seen_q  <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      req_sync_q <= {req_sync_q[Depth-2:0], req_q};
      if (load) begin
        out_q       <= word_q;
        out_valid_q <= 1'b1;
        req_seen_q  <= req_sync_q[Depth-1];
      end else if (out_valid_q && rcv_ready_i) begin
        out_valid_q <= 1'b0;
        ack_q       <= ~ack_q;
      end
    end
  end

  assign rcv_data_o  = out_q;
  assign rcv_valid_o = out_valid_q;
endmodule

module sdpb_1kx32 (
  input  logic        wr_clk_i,
  input  logic        wr_en_i,
  input  logic [9:0]  wr_addr_i,
  input  logic [31:0] wr_data_i,
  input  logic        rd_clk_i,
  input  logic        rd_rst_i,
  input  logic [9:0]  rd_addr_i,
  output logic [31:0] rd_data_o
);
  logic [31:0] mem_q [1024];
  logic [31:0] rd_q;

  always_ff @(posedge wr_clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge rd_clk_i or posedge rd_rst_i) begin
    if (rd_rst_i) begin
      rd_q <= '0;
    end else begin
      rd_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_q;
endmodule

module debug_pattern_gen #(
  parameter int unsigned FRAME_WIDTH  = 640,
  parameter int unsigned FRAME_HEIGHT = 480
) (
  input  logic        clk_cam,
  input  logic        reset_n,
  input  logic        clk_mem,
  input  logic        mem_controller_rdy,
  input  logic [9:0]  mem_rd_addr,
  output logic [31:0] pixel_data,
  output logic [1:0]  command_data,
  output logic        command_data_valid
);
  localparam int unsigned BarW = FRAME_WIDTH / 8;
  localparam int unsigned RowW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;

  typedef enum logic {StFill, StSend} state_e;

  logic            rst_cam;
  logic            rst_mem;
  state_e          state_q, state_d;
  logic [10:0]     col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic            buf_q, buf_d;
  logic [15:0]     lo_q, lo_d;
  logic [2:0]      bar;
  logic [15:0]     pixel;
  logic            snd_valid;
  logic            snd_ready;
  logic [1:0]      snd_data;
  logic [1:0]      we;
  logic [9:0]      wr_addr;
  logic [31:0]     wr_data;
  logic            rd_sel_q;
  logic [31:0]     rd_data [2];

  Reset_Synchronizer #(
    .EXTRA_DEPTH (1)
  ) u_rst_cam (
    .clk_i  (clk_cam),
    .rst_ni (reset_n),
    .rst_o  (rst_cam)
  );

  Reset_Synchronizer #(
    .EXTRA_DEPTH (1)
  ) u_rst_mem (
    .clk_i  (clk_mem),
    .rst_ni (reset_n),
    .rst_o  (rst_mem)
  );

  // Bar index by threshold compare, avoiding a divider.
  always_comb begin
    bar = 3'd0;
    for (int unsigned b = 1; b < 8; b++) begin
      if (32'(col_q) >= b * BarW) begin
        bar = 3'(b);
      end
    end
  end

  always_comb begin
    pixel = 16'h0000;
    unique case (bar)
      3'd0: pixel = 16'hFFFF;
      3'd1: pixel = 16'hFFE0;
      3'd2: pixel = 16'h07FF;
      3'd3: pixel = 16'h07E0;
      3'd4: pixel = 16'hF81F;
      3'd5: pixel = 16'hF800;
      3'd6: pixel = 16'h001F;
      3'd7: pixel = 16'h0000;
    endcase
  end

  always_ff @(posedge clk_cam or posedge rst_cam) begin
    if (rst_cam) begin
      state_q <= StFill;
      col_q   <= '0;
      row_q   <= '0;
      buf_q   <= 1'b0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      buf_q   <= buf_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    buf_d     = buf_q;
    lo_d      = lo_q;
    we        = '0;
    snd_valid = 1'b0;
    unique case (state_q)
      StFill: begin
        if (!col_q[0]) begin
          lo_d = pixel;
        end else begin
          we[buf_q] = 1'b1;
        end
        if (col_q == 11'(FRAME_WIDTH - 1)) begin
          state_d = StSend;
        end else begin
          col_d = col_q + 11'd1;
        end
      end
      StSend: begin
        snd_valid = 1'b1;
        if (snd_ready) begin
          state_d = StFill;
          col_d   = '0;
          buf_d   = ~buf_q;
          row_d   = (row_q == RowW'(FRAME_HEIGHT - 1)) ? '0 : row_q + 1'b1;
        end
      end
      default: state_d = StFill;
    endcase
  end

  assign wr_addr  = col_q[10:1];
  assign wr_data  = {pixel, lo_q};
  assign snd_data = {(row_q == '0), buf_q};

  CDC_Word_Synchronizer #(
    .WORD_WIDTH      (2),
    .EXTRA_CDC_DEPTH (1)
  ) u_cmd_cdc (
    .snd_clk_i   (clk_cam),
    .snd_rst_i   (rst_cam),
    .snd_data_i  (snd_data),
    .snd_valid_i (snd_valid),
    .snd_ready_o (snd_ready),
    .rcv_clk_i   (clk_mem),
    .rcv_rst_i   (rst_mem),
    .rcv_data_o  (command_data),
    .rcv_valid_o (command_data_valid),
    .rcv_ready_i (mem_controller_rdy)
  );

  for (genvar i = 0; i < 2; i++) begin : g_buf
    sdpb_1kx32 u_ram (
      .wr_clk_i  (clk_cam),
      .wr_en_i   (we[i]),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .rd_clk_i  (clk_mem),
      .rd_rst_i  (rst_mem),
      .rd_addr_i (mem_rd_addr),
      .rd_data_o (rd_data[i])
    );
  end

  // Read select follows the buffer named by the most recently accepted command.
  always_ff @(posedge clk_mem or posedge rst_mem) begin
    if (rst_mem) begin
      rd_sel_q <= 1'b0;
    end else if (command_data_valid && mem_controller_rdy) begin
      rd_sel_q <= command_data[0];
    end
  end

  assign pixel_data = rd_sel_q ? rd_data[1] : rd_data[0];
endmodule

// File: tb/tb_debug_pattern_gen.sv
// Bench for debug_pattern_gen: random acceptance delays and read addresses checked against a
// colour-bar and command-sequence model derived from the row/frame rules.

module tb_debug_pattern_gen;
  localparam int unsigned W = 640;
  localparam int unsigned H = 4;

  logic        clk_cam = 1'b0;
  logic        clk_mem = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_controller_rdy = 1'b0;
  logic [9:0]  mem_rd_addr = '0;
  logic [31:0] pixel_data;
  logic [1:0]  command_data;
  logic        command_data_valid;

  int checks   = 0;
  int failures = 0;
  int m_row    = 0;
  bit m_buf    = 1'b0;

  always #5 clk_cam = ~clk_cam;
  always #4 clk_mem = ~clk_mem;

  debug_pattern_gen #(
    .FRAME_WIDTH  (W),
    .FRAME_HEIGHT (H)
  ) dut (
    .clk_cam            (clk_cam),
    .reset_n            (reset_n),
    .clk_mem            (clk_mem),
    .mem_controller_rdy (mem_controller_rdy),
    .mem_rd_addr        (mem_rd_addr),
    .pixel_data         (pixel_data),
    .command_data       (command_data),
    .command_data_valid (command_data_valid)
  );

  function automatic logic [15:0] model_pixel(input int c);
    case (c / int'(W / 8))
      0:       return 16'hFFFF;
      1:       return 16'hFFE0;
      2:       return 16'h07FF;
      3:       return 16'h07E0;
      4:       return 16'hF81F;
      5:       return 16'hF800;
      6:       return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [31:0] model_word(input int a);
    return {model_pixel(2 * a + 1), model_pixel(2 * a)};
  endfunction

  function automatic logic [1:0] model_cmd();
    return {(m_row == 0), m_buf};
  endfunction

  task automatic model_advance();
    m_buf = !m_buf;
    m_row = (m_row + 1) % int'(H);
  endtask

  task automatic get_cmd(output bit ok, output logic [1:0] cmd);
    ok  = 1'b0;
    cmd = 2'bxx;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_mem);
      if (command_data_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      repeat ($urandom_range(0, 12)) @(negedge clk_mem);
      cmd = command_data;
      mem_controller_rdy = 1'b1;
      @(posedge clk_mem);
      #1;
      mem_controller_rdy = 1'b0;
    end
  endtask

  task automatic read_word(input int addr, output logic [31:0] data);
    @(negedge clk_mem);
    mem_rd_addr = 10'(addr);
    @(negedge clk_mem);
    data = pixel_data;
  endtask

  task automatic do_reset(input int cycles);
    mem_controller_rdy = 1'b0;
    #3;
    reset_n = 1'b0;
    repeat (cycles) @(posedge clk_cam);
    repeat (cycles) @(posedge clk_mem);
    #3;
    reset_n = 1'b1;
    m_row = 0;
    m_buf = 1'b0;
  endtask

  task automatic test_reset();
    mem_controller_rdy = 1'b0;
    reset_n = 1'b0;
    repeat (10) @(posedge clk_cam);
    repeat (10) @(posedge clk_mem);
    @(negedge clk_mem);
    checks++;
    if (command_data_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid: got %b expected 0", command_data_valid);
    end
    checks++;
    if (command_data !== 2'b00) begin
      failures++;
      $display("FAIL reset_cmd: got %b expected 00", command_data);
    end
    checks++;
    if (pixel_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_pixel: got %h expected 00000000", pixel_data);
    end
    #3;
    reset_n = 1'b1;
    m_row = 0;
    m_buf = 1'b0;
  endtask

  task automatic test_first_row();
    bit ok;
    logic [1:0] cmd, exp;
    logic [31:0] got;
    int addrs[$];
    get_cmd(ok, cmd);
    exp = model_cmd();
    checks++;
    if (!ok || cmd !== exp) begin
      failures++;
      $display("FAIL first_cmd: got %b arrived=%0d expected %b", cmd, ok, exp);
    end
    model_advance();
    addrs = '{0, 40, 319};
    repeat (5) addrs.push_back(int'($urandom_range(0, W / 2 - 1)));
    foreach (addrs[i]) begin
      read_word(addrs[i], got);
      checks++;
      if (got !== model_word(addrs[i])) begin
        failures++;
        $display("FAIL first_read[%0d]: got %h expected %h", addrs[i], got,
                 model_word(addrs[i]));
      end
    end
  endtask

  task automatic test_consecutive();
    bit ok;
    logic [1:0] cmd, exp;
    logic [31:0] got;
    int a;
    for (int r = 0; r < 2; r++) begin
      get_cmd(ok, cmd);
      exp = model_cmd();
      checks++;
      if (!ok || cmd !== exp) begin
        failures++;
        $display("FAIL consec_cmd[%0d]: got %b arrived=%0d expected %b", r, cmd, ok, exp);
      end
      model_advance();
      for (int k = 0; k < 6; k++) begin
        a = (k == 0) ? 120 : int'($urandom_range(0, W / 2 - 1));
        read_word(a, got);
        checks++;
        if (got !== model_word(a)) begin
          failures++;
          $display("FAIL consec_read[%0d]: got %h expected %h", a, got, model_word(a));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok, seen;
    logic [1:0] held, cmd, exp;
    logic [31:0] got;
    int a, bad;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_mem);
      if (command_data_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    held = command_data;
    exp  = model_cmd();
    checks++;
    if (!ok || held !== exp) begin
      failures++;
      $display("FAIL bp_cmd: got %b arrived=%0d expected %b", held, ok, exp);
    end
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_mem);
      checks++;
      if (command_data_valid !== 1'b1 || command_data !== held) begin
        failures++;
        bad++;
        if (bad <= 3) begin
          $display("FAIL bp_hold[%0d]: valid=%b data=%b required valid=1 data=%b", i,
                   command_data_valid, command_data, held);
        end
      end
    end
    mem_controller_rdy = 1'b1;
    @(posedge clk_mem);
    #1;
    mem_controller_rdy = 1'b0;
    model_advance();
    for (int k = 0; k < 4; k++) begin
      a = int'($urandom_range(0, W / 2 - 1));
      read_word(a, got);
      checks++;
      if (got !== model_word(a)) begin
        failures++;
        $display("FAIL bp_read[%0d]: got %h expected %h", a, got, model_word(a));
      end
    end
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_mem);
      if (command_data_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL bp_early_cmd: valid seen=1 before next row filled, required 0");
    end
    get_cmd(ok, cmd);
    exp = model_cmd();
    checks++;
    if (!ok || cmd !== exp) begin
      failures++;
      $display("FAIL bp_next_cmd: got %b arrived=%0d expected %b", cmd, ok, exp);
    end
    model_advance();
  endtask

  task automatic test_frame_wrap();
    bit ok;
    logic [1:0] cmd, exp;
    logic [31:0] got;
    int a;
    do_reset(4);
    for (int r = 0; r < 6; r++) begin
      get_cmd(ok, cmd);
      exp = model_cmd();
      checks++;
      if (!ok || cmd !== exp) begin
        failures++;
        $display("FAIL wrap_cmd[%0d]: got %b arrived=%0d expected %b", r, cmd, ok, exp);
      end
      model_advance();
      a = int'($urandom_range(0, W / 2 - 1));
      read_word(a, got);
      checks++;
      if (got !== model_word(a)) begin
        failures++;
        $display("FAIL wrap_read[%0d]: got %h expected %h", a, got, model_word(a));
      end
    end
  endtask

  task automatic test_reset_mid_row();
    bit ok;
    logic [1:0] cmd, exp;
    logic [31:0] got;
    int addrs[$];
    do_reset(4);
    for (int r = 0; r < 3; r++) begin
      get_cmd(ok, cmd);
      exp = model_cmd();
      checks++;
      if (!ok || cmd !== exp) begin
        failures++;
        $display("FAIL mid_pre_cmd[%0d]: got %b arrived=%0d expected %b", r, cmd, ok, exp);
      end
      model_advance();
    end
    repeat (W / 2) @(posedge clk_cam);
    #3;
    reset_n = 1'b0;
    repeat (3) @(posedge clk_mem);
    @(negedge clk_mem);
    checks++;
    if (command_data_valid !== 1'b0 || pixel_data !== 32'h0) begin
      failures++;
      $display("FAIL mid_in_reset: valid=%b pixel=%h required 0 and 00000000",
               command_data_valid, pixel_data);
    end
    #3;
    reset_n = 1'b1;
    m_row = 0;
    m_buf = 1'b0;
    get_cmd(ok, cmd);
    exp = model_cmd();
    checks++;
    if (!ok || cmd !== exp) begin
      failures++;
      $display("FAIL mid_first_cmd: got %b arrived=%0d expected %b", cmd, ok, exp);
    end
    model_advance();
    addrs = '{0, 319};
    repeat (6) addrs.push_back(int'($urandom_range(0, W / 2 - 1)));
    foreach (addrs[i]) begin
      read_word(addrs[i], got);
      checks++;
      if (got !== model_word(addrs[i])) begin
        failures++;
        $display("FAIL mid_read[%0d]: got %h expected %h", addrs[i], got,
                 model_word(addrs[i]));
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_row();
    test_consecutive();
    test_backpressure();
    test_frame_wrap();
    test_reset_mid_row();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
